// File: rtl/dm_arbiter_if.sv
// Request/response bundle for one data-memory requester.
// The master drives the request side and the slave (arbiter) drives the
// acceptance and read-response side.
interface dm_req_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          valid;
  logic          ready;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (
    output valid, we, lock, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  valid, we, lock, addr, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory with a
// combinational read and a synchronous write. Grants are combinational, read
// data and error flags come back one cycle after the transfer. A requester
// may lock the grant for up to MAX_LOCK consecutive transfers; the transfer
// that completes MAX_LOCK locked transfers forces the lock to release.
module dm_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int DEPTH    = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dm_req_if.slave       m0,
  dm_req_if.slave       m1,
  output logic [AW-1:0] dm_addr_o,
  output logic [DW-1:0] dm_wd_o,
  output logic          dm_we_o,
  input  logic [DW-1:0] dm_rd_i
);

  localparam int CW = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;        // 1: m1 had the last transfer
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  logic          gnt0_s, gnt1_s, xfer_s;
  logic          sel_we_s, sel_lock_s, in_range_s, stay_lock_s;

  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Grant selection: lock owner only, else round-robin on ties; nothing in reset.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0.valid && m1.valid) begin
            gnt0_s = last_q;
            gnt1_s = ~last_q;
          end else begin
            gnt0_s = m0.valid;
            gnt1_s = m1.valid;
          end
        end
        ST_LOCK0: gnt0_s = m0.valid;
        ST_LOCK1: gnt1_s = m1.valid;
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  assign xfer_s     = gnt0_s | gnt1_s;
  assign dm_addr_o  = gnt1_s ? m1.addr  : m0.addr;
  assign dm_wd_o    = gnt1_s ? m1.wdata : m0.wdata;
  assign sel_we_s   = gnt1_s ? m1.we    : m0.we;
  assign sel_lock_s = gnt1_s ? m1.lock  : m0.lock;
  assign in_range_s = (dm_addr_o < AW'(DEPTH));
  assign dm_we_o    = xfer_s & sel_we_s & in_range_s;

  assign m0.ready   = gnt0_s;
  assign m1.ready   = gnt1_s;
  assign m0.rvalid  = rvalid0_q;
  assign m1.rvalid  = rvalid1_q;
  assign m0.rdata   = rdata0_q;
  assign m1.rdata   = rdata1_q;
  assign m0.err     = err0_q;
  assign m1.err     = err1_q;

  // Lock budget: keep the lock only while this transfer leaves budget for another.
  always_comb begin
    stay_lock_s = 1'b0;
    if (state_q == ST_IDLE) begin
      stay_lock_s = (MAX_LOCK > 1) ? 1'b1 : 1'b0;
    end else begin
      stay_lock_s = (lock_cnt_q < CW'(MAX_LOCK - 1));
    end
  end

  // Next state: lock entry/extension/release and round-robin history.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    if (xfer_s) begin
      last_d = gnt1_s;
      if (sel_lock_s && stay_lock_s) begin
        state_d    = gnt1_s ? ST_LOCK1 : ST_LOCK0;
        lock_cnt_d = (state_q == ST_IDLE) ? CW'(1) : (lock_cnt_q + CW'(1));
      end else begin
        state_d    = ST_IDLE;
        lock_cnt_d = {CW{1'b0}};
      end
    end else begin
      state_d    = state_q;
      last_d     = last_q;
      lock_cnt_d = lock_cnt_q;
    end
  end

  // Response slot: read data (zero when out of range) and error for the granted port.
  always_comb begin
    rvalid0_d = gnt0_s & ~sel_we_s;
    rvalid1_d = gnt1_s & ~sel_we_s;
    err0_d    = gnt0_s & ~in_range_s;
    err1_d    = gnt1_s & ~in_range_s;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (rvalid0_d) begin
      rdata0_d = in_range_s ? dm_rd_i : {DW{1'b0}};
    end else begin
      rdata0_d = rdata0_q;
    end
    if (rvalid1_d) begin
      rdata1_d = in_range_s ? dm_rd_i : {DW{1'b0}};
    end else begin
      rdata1_d = rdata1_q;
    end
  end

  // State and response registers; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= {CW{1'b0}};
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= {DW{1'b0}};
      rdata1_q   <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, hand-written lock/reset
// sequences, then random traffic against a transaction-level reference model.
module tb_dm_arbiter;
  localparam int DW = 32, AW = 32, DEPTH = 32, MAX_LOCK = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          init_req;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wd, dm_rd;
  logic          dm_we;
  logic [DW-1:0] mem [DEPTH];

  dm_req_if #(.DW(DW), .AW(AW)) m0_if ();
  dm_req_if #(.DW(DW), .AW(AW)) m1_if ();

  dm_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if),
    .dm_addr_o(dm_addr), .dm_wd_o(dm_wd), .dm_we_o(dm_we), .dm_rd_i(dm_rd)
  );

  // Behavioural data memory: combinational read, write at the clock edge.
  // Out-of-range reads return garbage so the arbiter has to zero them.
  assign dm_rd = (dm_addr < DEPTH) ? mem[dm_addr[4:0]] : (32'hBAD0_0000 | dm_addr);
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (dm_we) begin
      mem[dm_addr[4:0]] <= dm_wd;
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: lock owner, count of locked transfers in the current
  // burst, last winner, pending responses and a shadow copy of memory.
  int          own, burst, lastw, e_win;
  logic        mrv [2], mer [2];
  logic [31:0] mrd [2];
  logic [31:0] shadow [DEPTH];
  logic        e_rdy0, e_rdy1, e_dmwe, e_rv0, e_rv1, e_er0, e_er1;
  logic [31:0] e_rd0, e_rd1, e_addr, e_wd;
  logic        c_rdy0, c_rdy1, c_we, c_rv0, c_rv1, c_er0, c_er1;
  logic [31:0] c_rd0, c_rd1, c_addr, c_wd;

  task automatic model_reset();
    own = -1; burst = 0; lastw = 1;
    for (int p = 0; p < 2; p++) begin mrv[p] = 1'b0; mer[p] = 1'b0; mrd[p] = 32'h0; end
  endtask

  // One clock cycle: called at posedge+1, drives inputs, samples at negedge,
  // computes model expectations, advances the model at the next posedge.
  task automatic cyc(input logic v0, input logic we0, input logic lk0, input logic [31:0] a0,
                     input logic [31:0] d0, input logic v1, input logic we1, input logic lk1,
                     input logic [31:0] a1, input logic [31:0] d1);
    int w;
    logic wr, lk, oor;
    logic [31:0] a, d;
    m0_if.valid = v0; m0_if.we = we0; m0_if.lock = lk0; m0_if.addr = a0; m0_if.wdata = d0;
    m1_if.valid = v1; m1_if.we = we1; m1_if.lock = lk1; m1_if.addr = a1; m1_if.wdata = d1;
    #4;
    c_rdy0 = m0_if.ready;  c_rdy1 = m1_if.ready;  c_we = dm_we;
    c_rv0  = m0_if.rvalid; c_rv1  = m1_if.rvalid; c_er0 = m0_if.err; c_er1 = m1_if.err;
    c_rd0  = m0_if.rdata;  c_rd1  = m1_if.rdata;  c_addr = dm_addr; c_wd = dm_wd;
    if (own >= 0) w = ((own == 0) ? v0 : v1) ? own : -1;
    else if (v0 && v1) w = 1 - lastw;
    else if (v0) w = 0;
    else if (v1) w = 1;
    else w = -1;
    e_win = w;
    a = (w == 1) ? a1 : a0;   d = (w == 1) ? d1 : d0;
    wr = (w == 1) ? we1 : we0; lk = (w == 1) ? lk1 : lk0;
    oor = (a >= DEPTH);
    e_rdy0 = (w == 0); e_rdy1 = (w == 1);
    e_addr = a; e_wd = d;
    e_dmwe = (w >= 0) && wr && !oor;
    e_rv0 = mrv[0]; e_rv1 = mrv[1]; e_er0 = mer[0]; e_er1 = mer[1];
    e_rd0 = mrd[0]; e_rd1 = mrd[1];
    @(posedge clk);
    mrv[0] = 1'b0; mrv[1] = 1'b0; mer[0] = 1'b0; mer[1] = 1'b0;
    if (w >= 0) begin
      lastw  = w;
      mrv[w] = !wr;
      mer[w] = oor;
      if (!wr) mrd[w] = oor ? 32'h0 : shadow[a[4:0]];
      if (wr && !oor) shadow[a[4:0]] = d;
      if (lk) begin
        burst = (own == w) ? burst + 1 : 1;
        if (burst >= MAX_LOCK) begin own = -1; burst = 0; end
        else own = w;
      end else begin
        own = -1; burst = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_if.valid = 1'b0; m1_if.valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  ictl;  // v0 we0 v1 we1
    logic [31:0] a0, d0, a1, d1;
    logic [6:0]  ex;    // rdy0 rdy1 dmwe rv0 rv1 er0 er1
    logic [31:0] rd0, rd1;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] ictl, input logic [31:0] a0, input logic [31:0] d0,
                              input logic [31:0] a1, input logic [31:0] d1, input logic [6:0] ex,
                              input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.ictl = ictl; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.ex = ex; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  vec_t tbl [19];

  initial begin
    logic v0, v1, w0, w1, l0, l1;
    logic [31:0] a0, a1;
    // both requesting: m0, m1, m0, m1 with responses one cycle behind
    tbl[0]  = mk(4'b1010, 32'd1, 32'd0, 32'd2, 32'd0, 7'b1000000, 32'h0, 32'h0);
    tbl[1]  = mk(4'b1010, 32'd1, 32'd0, 32'd2, 32'd0, 7'b0101000, 32'h1000_0001, 32'h0);
    tbl[2]  = mk(4'b1010, 32'd1, 32'd0, 32'd2, 32'd0, 7'b1000100, 32'h0, 32'h1000_0002);
    tbl[3]  = mk(4'b1010, 32'd1, 32'd0, 32'd2, 32'd0, 7'b0101000, 32'h1000_0001, 32'h0);
    // m0 write 3 then read back
    tbl[4]  = mk(4'b1100, 32'd3, 32'hDEAD_BEEF, 32'd0, 32'd0, 7'b1010100, 32'h0, 32'h1000_0002);
    tbl[5]  = mk(4'b1000, 32'd3, 32'd0, 32'd0, 32'd0, 7'b1000000, 32'h0, 32'h0);
    tbl[6]  = mk(4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 7'b0001000, 32'hDEAD_BEEF, 32'h0);
    // m1 out-of-range write and read
    tbl[7]  = mk(4'b0011, 32'd0, 32'd0, 32'd40, 32'h1234, 7'b0100000, 32'h0, 32'h0);
    tbl[8]  = mk(4'b0010, 32'd0, 32'd0, 32'd40, 32'd0, 7'b0100001, 32'h0, 32'h0);
    tbl[9]  = mk(4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 7'b0000101, 32'h0, 32'h0);
    tbl[10] = mk(4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 7'b0000000, 32'h0, 32'h0);
    // back-to-back read after write on m1
    tbl[11] = mk(4'b0011, 32'd0, 32'd0, 32'd5, 32'hA5A5, 7'b0110000, 32'h0, 32'h0);
    tbl[12] = mk(4'b0010, 32'd0, 32'd0, 32'd5, 32'd0, 7'b0100000, 32'h0, 32'h0);
    tbl[13] = mk(4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 7'b0000100, 32'h0, 32'hA5A5);
    // DEPTH boundary: 31 in range, 32 out of range
    tbl[14] = mk(4'b1000, 32'd31, 32'd0, 32'd0, 32'd0, 7'b1000000, 32'h0, 32'h0);
    tbl[15] = mk(4'b1000, 32'd32, 32'd0, 32'd0, 32'd0, 7'b1001000, 32'h1000_001F, 32'h0);
    tbl[16] = mk(4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 7'b0001010, 32'h0, 32'h0);
    tbl[17] = mk(4'b1100, 32'd32, 32'h5555, 32'd0, 32'd0, 7'b1000000, 32'h0, 32'h0);
    tbl[18] = mk(4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 7'b0000010, 32'h0, 32'h0);

    for (int i = 0; i < DEPTH; i++) shadow[i] = 32'h1000_0000 + i;
    model_reset();
    rst_n = 1'b0; init_req = 1'b1;
    m0_if.valid = 1'b1; m0_if.we = 1'b1; m0_if.lock = 1'b0; m0_if.addr = 32'd7; m0_if.wdata = 32'hFFFF_FFFF;
    m1_if.valid = 1'b0; m1_if.we = 1'b0; m1_if.lock = 1'b0; m1_if.addr = 32'd0; m1_if.wdata = 32'h0;
    @(posedge clk);
    #1 init_req = 1'b0;
    @(posedge clk);
    #1;
    // reset state, with a write request held during reset
    chk("rst_rdy0", m0_if.ready, 1'b0);   chk("rst_rdy1", m1_if.ready, 1'b0);
    chk("rst_dmwe", dm_we, 1'b0);
    chk("rst_rv0", m0_if.rvalid, 1'b0);  chk("rst_rv1", m1_if.rvalid, 1'b0);
    chk("rst_er0", m0_if.err, 1'b0);     chk("rst_er1", m1_if.err, 1'b0);
    chk("rst_rd0", m0_if.rdata, 32'h0);  chk("rst_rd1", m1_if.rdata, 32'h0);
    chk("rst_mem7", mem[7], 32'h1000_0007);
    m0_if.valid = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed vector table
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].ictl[3], tbl[i].ictl[2], 1'b0, tbl[i].a0, tbl[i].d0,
          tbl[i].ictl[1], tbl[i].ictl[0], 1'b0, tbl[i].a1, tbl[i].d1);
      chk($sformatf("t%0d_rdy0", i), c_rdy0, tbl[i].ex[6]);
      chk($sformatf("t%0d_rdy1", i), c_rdy1, tbl[i].ex[5]);
      chk($sformatf("t%0d_dmwe", i), c_we,   tbl[i].ex[4]);
      chk($sformatf("t%0d_rv0", i),  c_rv0,  tbl[i].ex[3]);
      chk($sformatf("t%0d_rv1", i),  c_rv1,  tbl[i].ex[2]);
      chk($sformatf("t%0d_er0", i),  c_er0,  tbl[i].ex[1]);
      chk($sformatf("t%0d_er1", i),  c_er1,  tbl[i].ex[0]);
      if (tbl[i].ex[3]) chk($sformatf("t%0d_rd0", i), c_rd0, tbl[i].rd0);
      if (tbl[i].ex[2]) chk($sformatf("t%0d_rd1", i), c_rd1, tbl[i].rd1);
    end

    // m1 locks for three reads while m0 waits, releases on the fourth
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("l1_pre_rdy0", c_rdy0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, (i < 3), 32'd2, 32'd0);
      chk($sformatf("l1_%0d_rdy0", i), c_rdy0, 1'b0);
      chk($sformatf("l1_%0d_rdy1", i), c_rdy1, 1'b1);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
    chk("l1_rel_rdy0", c_rdy0, 1'b1);
    chk("l1_rel_rdy1", c_rdy1, 1'b0);

    // m0 holds lock for six cycles: forced release after the 4th transfer
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b1, i, 32'd0, 1'b1, 1'b0, 1'b0, 32'd9, 32'd0);
      chk($sformatf("ml_%0d_rdy0", i), c_rdy0, (i != 4));
      chk($sformatf("ml_%0d_rdy1", i), c_rdy1, (i == 4));
      chk($sformatf("ml_%0d_rv0", i),  c_rv0,  (i >= 1 && i <= 4));
      chk($sformatf("ml_%0d_rv1", i),  c_rv1,  (i == 5));
    end

    // reset asserted mid-lock with a read response pending
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, 32'd8, 32'd0);
    chk("mr_rdy0a", c_rdy0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 32'd4, 32'd0, 1'b1, 1'b0, 1'b0, 32'd8, 32'd0);
    chk("mr_rdy1b", c_rdy1, 1'b0);
    m0_if.we = 1'b1; m0_if.addr = 32'd6; m0_if.wdata = 32'hFFFF_0000;
    rst_n = 1'b0;
    #1;
    chk("mr_rv0", m0_if.rvalid, 1'b0);
    chk("mr_rdy0", m0_if.ready, 1'b0);
    chk("mr_dmwe", dm_we, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mr_mem6", mem[6], shadow[6]);
    cyc(1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
    chk("mr_post_rdy0", c_rdy0, 1'b1);
    chk("mr_post_rdy1", c_rdy1, 1'b0);
    chk("mr_post_rv0",  c_rv0,  1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
    chk("mr_idle_rdy1", c_rdy1, 1'b1);

    // random traffic against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      v0 = ($urandom_range(0, 9) < 7); v1 = ($urandom_range(0, 9) < 7);
      w0 = $urandom_range(0, 1);       w1 = $urandom_range(0, 1);
      l0 = ($urandom_range(0, 2) == 0); l1 = ($urandom_range(0, 2) == 0);
      a0 = $urandom_range(0, 39);      a1 = $urandom_range(0, 39);
      cyc(v0, w0, l0, a0, $urandom, v1, w1, l1, a1, $urandom);
      chk("rnd_rdy0", c_rdy0, e_rdy0);
      chk("rnd_rdy1", c_rdy1, e_rdy1);
      chk("rnd_dmwe", c_we,   e_dmwe);
      chk("rnd_rv0",  c_rv0,  e_rv0);
      chk("rnd_rv1",  c_rv1,  e_rv1);
      chk("rnd_er0",  c_er0,  e_er0);
      chk("rnd_er1",  c_er1,  e_er1);
      if (e_rv0) chk("rnd_rd0", c_rd0, e_rd0);
      if (e_rv1) chk("rnd_rd1", c_rd1, e_rd1);
      if (e_win >= 0) chk("rnd_addr", c_addr, e_addr);
      if (e_dmwe) chk("rnd_wd", c_wd, e_wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
